// File: rtl/if_fetch_pkg.sv
// ============================================================================
// Module : if_fetch_pkg
// Brief  : Shared widths, fetch-state encodings and NOP encoding for if_fetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package if_fetch_pkg;

    localparam int WORD_W      = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/if_fetch_if.sv
// ============================================================================
// Module : if_fetch_if
// Brief  : Instruction-memory bus and decode handshake of the fetch stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface if_fetch_if;
    import if_fetch_pkg::*;

    logic [WORD_W-1:0] imem_adr;
    logic              imem_load;
    logic [WORD_W-1:0] imem_in;
    logic [WORD_W-1:0] imem_out;
    logic              imem_done;
    logic              redirect;
    logic [WORD_W-1:0] redirect_pc;
    logic              id_valid;
    logic              id_ready;
    logic [WORD_W-1:0] id_instr;
    logic [WORD_W-1:0] id_pc;
    logic              fault;

    modport master (
        output imem_adr, imem_load, imem_in, id_valid, id_instr, id_pc, fault,
        input  imem_out, imem_done, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_adr, imem_load, imem_in, id_valid, id_instr, id_pc, fault,
        output imem_out, imem_done, redirect, redirect_pc, id_ready
    );

endinterface

`default_nettype wire

// File: rtl/if_fetch_fifo.sv
// ============================================================================
// Module : fetch_fifo
// Brief  : Synchronous FIFO with flush; flush overrides push and pop.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic                     i_pop,
    input  wire logic                     i_flush,
    input  wire logic [WIDTH-1:0]         i_din,
    output logic      [WIDTH-1:0]         o_dout,
    output logic      [$clog2(DEPTH):0]   o_count,
    output logic                          o_full,
    output logic                          o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_pop;

    assign w_do_pop = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_count == DEPTH[c_ptr_w:0]);
    assign o_empty = (r_count == '0);
    assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
// Module : if_fetch
// Brief  : Fetch stage: PC, single in-flight imem read, FIFO toward decode.
//          IF_ALIGN_CHECK_EN enables the misaligned-redirect fault/HALT path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                QDEPTH   = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    if_fetch_if.master  bus
);

    localparam int               c_cnt_w = $clog2(QDEPTH) + 1;
    localparam logic [c_cnt_w:0] c_depth = QDEPTH[c_cnt_w:0];

    fetch_state_t        r_state;
    fetch_state_t        w_state_next;
    logic [WORD_W-1:0]   r_pc;
    logic [WORD_W-1:0]   r_inflight_pc;
    logic                r_inflight;
    logic [WORD_W-1:0]   w_pc_next;
    logic [WORD_W-1:0]   w_target;
    logic                w_misalign;
    logic                w_issue;
    logic                w_retry;
    logic                w_push;
    logic                w_pop;
    logic [c_cnt_w-1:0]  w_count;
    logic [c_cnt_w:0]    w_used;
    logic [c_cnt_w:0]    w_limit;
    logic                w_full;
    logic                w_empty;
    logic [2*WORD_W-1:0] w_head;

`ifdef IF_ALIGN_CHECK_EN
    logic r_fault;

    assign w_misalign = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
    assign w_target   = bus.redirect_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_misalign) begin
            r_fault <= 1'b1;
        end
    end

    assign bus.fault = r_fault;
`else
    assign w_misalign = 1'b0;
    assign w_target   = bus.redirect_pc & ~32'h3;
    assign bus.fault  = 1'b0;
`endif

    assign w_pop   = !w_empty && bus.id_ready;
    assign w_retry = r_inflight && !bus.imem_done;
    assign w_push  = r_inflight && bus.imem_done && !bus.redirect;

    // A pop this cycle frees a slot before the new read returns, which keeps
    // the stage at one instruction per cycle with only QDEPTH entries.
    assign w_used  = {1'b0, w_count} + {{c_cnt_w{1'b0}}, r_inflight};
    assign w_limit = c_depth + {{c_cnt_w{1'b0}}, w_pop};

    // A failed capture must not be overtaken by a younger read.
    assign w_issue = (r_state == FETCH) && !bus.redirect && !w_retry &&
                     (w_used < w_limit);

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        if (w_misalign) begin
            w_state_next = HALT;
        end
        if (bus.redirect) begin
            w_pc_next = w_target;
        end else if (w_issue) begin
            w_pc_next = r_pc + 32'(INSTR_BYTES);
        end else if (w_retry) begin
            w_pc_next = r_inflight_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (2*WORD_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect),
        .i_din   ({r_inflight_pc, bus.imem_out}),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_full));

    assign bus.imem_adr  = r_pc;
    assign bus.imem_load = 1'b0;
    assign bus.imem_in   = '0;
    assign bus.id_valid  = !w_empty;
    assign bus.id_pc     = w_head[2*WORD_W-1:WORD_W];
    assign bus.id_instr  = w_head[WORD_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ============================================================================
// Module : tb_if_fetch
// Brief  : Self-checking bench for if_fetch with an in-order PC scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_q = NOP_INSTR;
    int          n_checks = 0;
    int          n_fail = 0;

    if_fetch_if bus();

    if_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(QD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            32'hC:   return 32'h44;
            default: return a ^ 32'hC0DE_0000;
        endcase
    endfunction

    // Memory returns the word for the address presented in the previous cycle.
    always @(posedge clk) mem_q <= mem_word(bus.imem_adr);
    assign bus.imem_out = mem_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.id_ready    = 1'b0;
        bus.imem_done   = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got  [7];
        logic [31:0] want [7];
        string       nm   [7];
        do_reset();
        bus.id_ready = 1'b1;
        repeat (5) step();
        rst = 1'b1;
        step();
        got  = '{bus.imem_adr, 32'(bus.imem_load), bus.imem_in, 32'(bus.id_valid),
                 bus.id_instr, bus.id_pc, 32'(bus.fault)};
        want = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        nm   = '{"rst_imem_adr", "rst_imem_load", "rst_imem_in", "rst_id_valid",
                 "rst_id_instr", "rst_id_pc", "rst_fault"};
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (got[i] !== want[i]) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", nm[i], got[i], want[i]);
            end
        end
        rst = 1'b0;
        step();
        step();
        n_checks++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || bus.id_instr !== 32'h11) begin
            n_fail++;
            $display("FAIL rst_restart: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=11",
                     bus.id_valid, bus.id_pc, bus.id_instr);
        end
    endtask

    task automatic test_basic();
        logic [31:0] e_instr [4];
        e_instr = '{32'h11, 32'h22, 32'h33, 32'h44};
        do_reset();
        bus.id_ready = 1'b1;
        step();
        n_checks++;
        if (bus.id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_cycle1_valid: got %b expected 0", bus.id_valid);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(4*i) || bus.id_instr !== e_instr[i]) begin
                n_fail++;
                $display("FAIL basic_seq[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         i, bus.id_valid, bus.id_pc, bus.id_instr, 32'(4*i), e_instr[i]);
            end
            step();
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (6) step();
        n_checks++;
        if (bus.imem_adr !== 32'(4*QD)) begin
            n_fail++;
            $display("FAIL stall_pc: got %h expected %h", bus.imem_adr, 32'(4*QD));
        end
        bus.id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(4*i) || bus.id_instr !== mem_word(32'(4*i))) begin
                n_fail++;
                $display("FAIL stall_drain[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h",
                         i, bus.id_valid, bus.id_pc, bus.id_instr, 32'(4*i));
            end
            step();
        end
    endtask

    task automatic redirect_and_expect(input logic [31:0] target, input string tag);
        bus.redirect    = 1'b1;
        bus.redirect_pc = target;
        step();
        bus.redirect = 1'b0;
        n_checks++;
        if (bus.id_valid !== 1'b0 || bus.imem_adr !== target) begin
            n_fail++;
            $display("FAIL %s_r1: got v=%b adr=%h expected v=0 adr=%h",
                     tag, bus.id_valid, bus.imem_adr, target);
        end
        step();
        n_checks++;
        if (bus.id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_r2: got v=%b expected 0", tag, bus.id_valid);
        end
        step();
        n_checks++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== target || bus.id_instr !== mem_word(target)) begin
            n_fail++;
            $display("FAIL %s_r3: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                     tag, bus.id_valid, bus.id_pc, bus.id_instr, target, mem_word(target));
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (6) step();
        redirect_and_expect(32'h40, "redir_full");
        bus.id_ready = 1'b1;
        step();
        n_checks++;
        if (bus.id_pc !== 32'h44) begin
            n_fail++;
            $display("FAIL redir_full_next: got %h expected 00000044", bus.id_pc);
        end
        do_reset();
        bus.id_ready = 1'b1;
        repeat (4) step();
        redirect_and_expect(32'h80, "redir_stream");
        step();
        n_checks++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h84) begin
            n_fail++;
            $display("FAIL redir_stream_next: got v=%b pc=%h expected v=1 pc=00000084",
                     bus.id_valid, bus.id_pc);
        end
    endtask

    task automatic test_done_drop();
        logic [31:0] prev_adr = 32'hFFFF_FFFF;
        logic [31:0] exp_pc   = 32'h0;
        bit          dropped  = 1'b0;
        int          seen8    = 0;
        int          delivered = 0;
        do_reset();
        bus.id_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            bus.imem_done = 1'b1;
            if (prev_adr == 32'h8 && !dropped) begin
                bus.imem_done = 1'b0;
                dropped = 1'b1;
            end
            if (bus.id_valid) begin
                n_checks++;
                if (bus.id_pc !== exp_pc || bus.id_instr !== mem_word(exp_pc)) begin
                    n_fail++;
                    $display("FAIL drop_order: got pc=%h instr=%h expected pc=%h instr=%h",
                             bus.id_pc, bus.id_instr, exp_pc, mem_word(exp_pc));
                end
                if (bus.id_pc == 32'h8) seen8++;
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            prev_adr = bus.imem_adr;
            step();
        end
        bus.imem_done = 1'b1;
        n_checks++;
        if (seen8 != 1 || delivered < 8) begin
            n_fail++;
            $display("FAIL drop_once: got pc8_count=%0d delivered=%0d expected 1 and >=8",
                     seen8, delivered);
        end
    endtask

    task automatic test_align();
        do_reset();
        bus.id_ready = 1'b1;
        repeat (4) step();
`ifdef IF_ALIGN_CHECK_EN
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h42;
        step();
        bus.redirect = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (bus.fault !== 1'b1 || bus.id_valid !== 1'b0 || bus.imem_adr !== 32'h42) begin
                n_fail++;
                $display("FAIL align_halt[%0d]: got fault=%b v=%b adr=%h expected 1 0 00000042",
                         i, bus.fault, bus.id_valid, bus.imem_adr);
            end
            step();
        end
        do_reset();
        n_checks++;
        if (bus.fault !== 1'b0) begin
            n_fail++;
            $display("FAIL align_fault_clear: got %b expected 0", bus.fault);
        end
`else
        redirect_and_expect(32'h42 & ~32'h3, "align_mask");
        bus.redirect_pc = 32'h42;
        n_checks++;
        if (bus.fault !== 1'b0) begin
            n_fail++;
            $display("FAIL align_fault: got %b expected 0", bus.fault);
        end
`endif
    endtask

    task automatic test_wrap_flush();
        logic [31:0] wrap_pcs [4];
        wrap_pcs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        do_reset();
        bus.id_ready = 1'b1;
        repeat (3) step();
        redirect_and_expect(32'hFFFF_FFF8, "wrap");
        for (int i = 1; i < 4; i++) begin
            step();
            n_checks++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== wrap_pcs[i]) begin
                n_fail++;
                $display("FAIL wrap_seq[%0d]: got v=%b pc=%h expected v=1 pc=%h",
                         i, bus.id_valid, bus.id_pc, wrap_pcs[i]);
            end
        end
        do_reset();
        bus.id_ready = 1'b1;
        repeat (3) step();
        redirect_and_expect(32'hFFFF_FFF8, "flush_pre");
        step();
        // Head is FFFF_FFFC and accepted while the redirect flushes everything behind it.
        redirect_and_expect(32'h100, "flush_hs");
    endtask

    task automatic test_random();
        logic [31:0] exp_pc = 32'h0;
        logic [31:0] target;
        int          delivered = 0;
        bit          rdy;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rdy           = ($urandom_range(0, 99) < 70);
            bus.id_ready  = rdy;
            bus.imem_done = ($urandom_range(0, 99) < 80);
            if (!bus.id_valid) begin
                n_checks++;
                if (bus.id_pc !== 32'h0 || bus.id_instr !== 32'h0) begin
                    n_fail++;
                    $display("FAIL rand_empty_head: got pc=%h instr=%h expected 0 0",
                             bus.id_pc, bus.id_instr);
                end
            end else if (rdy) begin
                n_checks++;
                if (bus.id_pc !== exp_pc || bus.id_instr !== mem_word(exp_pc)) begin
                    n_fail++;
                    $display("FAIL rand_order: got pc=%h instr=%h expected pc=%h instr=%h",
                             bus.id_pc, bus.id_instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            bus.redirect = ($urandom_range(0, 99) < 4);
            if (bus.redirect) begin
                target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'h0000_FFFC);
                bus.redirect_pc = target;
                exp_pc = target;
            end
            step();
        end
        bus.redirect = 1'b0;
        n_checks++;
        if (delivered < 100) begin
            n_fail++;
            $display("FAIL rand_progress: got %0d deliveries expected >=100", delivered);
        end
    endtask

    initial begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.id_ready    = 1'b0;
        bus.imem_done   = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_done_drop();
        test_align();
        test_wrap_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
